axis_credit_fifo: RTL

- Downstream companion to the allow-throttled AXI4-Stream gatekeeper: a first-word-fall-through (FWFT) FIFO that absorbs the gated stream.
- Returns one allow pulse per frame drained from its output, closing a credit loop so upstream never overruns the buffer.
- After reset it issues C_INIT_CREDITS initial allow pulses to prime the gatekeeper.
- Its m_allow drives the gatekeeper's s_allow.

---
 rtl/axis_credit_fifo.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/axis_credit_fifo.sv
`default_nettype none
// ============================================================================
// Module   : axis_credit_fifo
// Purpose  : FWFT AXI4-Stream FIFO that returns one allow credit per frame
//            drained, priming the upstream gatekeeper with initial credits.
// Revision : 1.0  initial release
// ============================================================================
module axis_credit_fifo #(
    parameter int C_AXIS_DATA_BYTES  = 8,
    parameter int C_AXIS_USE_TKEEP   = 0,
    parameter int C_AXIS_TUSER_WIDTH = 0,
    parameter int C_AXIS_USE_TLAST   = 0,
    parameter int C_FIFO_DEPTH_LOG2  = 4,
    parameter int C_INIT_CREDITS     = 4
) (
    input  logic                                                      aclk,
    input  logic                                                      aresetn,
    input  logic [C_AXIS_DATA_BYTES*8-1:0]                            s_axis_tdata,
    input  logic [C_AXIS_DATA_BYTES-1:0]                              s_axis_tkeep,
    input  logic [((C_AXIS_TUSER_WIDTH > 0) ? C_AXIS_TUSER_WIDTH : 1)-1:0] s_axis_tuser,
    input  logic                                                      s_axis_tvalid,
    input  logic                                                      s_axis_tlast,
    output logic                                                      s_axis_tready,
    output logic [C_AXIS_DATA_BYTES*8-1:0]                            m_axis_tdata,
    output logic [C_AXIS_DATA_BYTES-1:0]                              m_axis_tkeep,
    output logic [((C_AXIS_TUSER_WIDTH > 0) ? C_AXIS_TUSER_WIDTH : 1)-1:0] m_axis_tuser,
    output logic                                                      m_axis_tvalid,
    output logic                                                      m_axis_tlast,
    input  logic                                                      m_axis_tready,
    output logic                                                      m_allow,
    output logic [C_FIFO_DEPTH_LOG2:0]                                fifo_count,
    output logic                                                      credit_err
);

    localparam int DW    = C_AXIS_DATA_BYTES * 8;
    localparam int KW    = C_AXIS_DATA_BYTES;
    localparam int UW    = (C_AXIS_TUSER_WIDTH > 0) ? C_AXIS_TUSER_WIDTH : 1;
    localparam int N     = C_FIFO_DEPTH_LOG2;
    localparam int DEPTH = 1 << N;

    typedef enum logic [0:0] {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N:0]     wr_ptr_q, wr_ptr_d;
    logic [N:0]     rd_ptr_q, rd_ptr_d;
    logic [8:0]     pending_q, pending_d;
    logic           credit_err_q, credit_err_d;

    logic           w_full, w_empty, w_wr_en, w_rd_en, w_frame_out;
    logic [N-1:0]   w_wr_idx, w_rd_idx;
    logic           w_unused;

    logic [DW-1:0]  data_mem [DEPTH];
    logic           last_mem [DEPTH];

    assign w_wr_idx      = wr_ptr_q[N-1:0];
    assign w_rd_idx      = rd_ptr_q[N-1:0];
    assign w_full        = (wr_ptr_q[N] != rd_ptr_q[N]) && (w_wr_idx == w_rd_idx);
    assign w_empty       = (wr_ptr_q == rd_ptr_q);
    assign s_axis_tready = !w_full && (state_q == ST_RUN);
    assign m_axis_tvalid = !w_empty;
    assign w_wr_en       = s_axis_tvalid && s_axis_tready;
    assign w_rd_en       = m_axis_tvalid && m_axis_tready;
    // Credits are returned only when a whole frame has left the output.
    assign w_frame_out   = w_rd_en && ((C_AXIS_USE_TLAST == 0) || m_axis_tlast);
    assign m_allow       = (state_q == ST_RUN) && (pending_q != 9'd0);
    assign fifo_count    = wr_ptr_q - rd_ptr_q;
    assign credit_err    = credit_err_q;
    assign w_unused      = ^{s_axis_tkeep, s_axis_tuser};

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HOLD: state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_HOLD;
        endcase
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q + {{N{1'b0}}, w_wr_en};
        rd_ptr_d     = rd_ptr_q + {{N{1'b0}}, w_rd_en};
        pending_d    = pending_q + {8'd0, w_frame_out} - {8'd0, m_allow};
        credit_err_d = credit_err_q || ((state_q == ST_RUN) && s_axis_tvalid && w_full);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_HOLD;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            pending_q    <= 9'(C_INIT_CREDITS);
            credit_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            pending_q    <= pending_d;
            credit_err_q <= credit_err_d;
        end
    end

    // Storage is deliberately left unreset; the pointers define what is valid.
    always_ff @(posedge aclk) begin
        if (w_wr_en) begin
            data_mem[w_wr_idx] <= s_axis_tdata;
            last_mem[w_wr_idx] <= s_axis_tlast;
        end
    end

    assign m_axis_tdata = data_mem[w_rd_idx];
    assign m_axis_tlast = last_mem[w_rd_idx];

    generate
        if (C_AXIS_USE_TKEEP != 0) begin : g_keep
            logic [KW-1:0] keep_mem [DEPTH];
            always_ff @(posedge aclk) begin
                if (w_wr_en) keep_mem[w_wr_idx] <= s_axis_tkeep;
            end
            assign m_axis_tkeep = keep_mem[w_rd_idx];
        end else begin : g_no_keep
            // Without stored keep every byte of a beat is reported valid.
            assign m_axis_tkeep = '1;
        end
    endgenerate

    generate
        if (C_AXIS_TUSER_WIDTH > 0) begin : g_user
            logic [UW-1:0] user_mem [DEPTH];
            always_ff @(posedge aclk) begin
                if (w_wr_en) user_mem[w_wr_idx] <= s_axis_tuser;
            end
            assign m_axis_tuser = user_mem[w_rd_idx];
        end else begin : g_no_user
            assign m_axis_tuser = '0;
        end
    endgenerate

`ifndef SYNTHESIS
    // Returning more frames than were granted means the upstream overran us.
    a_pending_bounded : assert property (@(posedge aclk) disable iff (!aresetn)
        pending_q <= 9'(C_INIT_CREDITS));
`endif

endmodule
`default_nettype wire
